// File: rtl/cprv_pkg.sv
// Shared constants and types for the cprv64g pipeline slice: opcodes, access sizes,
// and the memory-stage state encoding.
package cprv_pkg;

  localparam int DATA_WIDTH_DEF = 64;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

endpackage

// File: rtl/cprv_lsu_align.sv
// Combinational load/store alignment: store data shift and byte strobes,
// load byte-lane extraction with sign/zero extension, and misalignment detection.
module cprv_lsu_align
  import cprv_pkg::*;
(
  input  logic [2:0]                off,
  input  logic [2:0]                funct3,
  input  logic                      is_store,
  input  logic [DATA_WIDTH_DEF-1:0] store_data,
  input  logic [DATA_WIDTH_DEF-1:0] load_word,
  output logic [DATA_WIDTH_DEF-1:0] wdata,
  output logic [7:0]                wstrb,
  output logic [DATA_WIDTH_DEF-1:0] load_data,
  output logic                      misalign
);

  mem_size_e             size;
  logic [DATA_WIDTH_DEF-1:0] shifted;

  assign size    = mem_size_e'(funct3[1:0]);
  assign wdata   = store_data << {off, 3'b000};
  assign shifted = load_word >> {off, 3'b000};

  always_comb begin
    wstrb     = 8'h00;
    misalign  = 1'b0;
    load_data = '0;
    case (size)
      SIZE_B: begin
        wstrb     = 8'h01 << off;
        load_data = funct3[2] ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        wstrb     = 8'h03 << off;
        misalign  = off[0];
        load_data = funct3[2] ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        wstrb     = 8'h0F << off;
        misalign  = |off[1:0];
        load_data = funct3[2] ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      SIZE_D: begin
        wstrb     = 8'hFF;
        misalign  = |off;
        load_data = shifted;
      end
      default: ;
    endcase
    // Stores have no unsigned variants, so funct3[2] marks an illegal store.
    if (is_store && funct3[2]) misalign = 1'b1;
  end

endmodule

// File: rtl/cprv_mem_stage.sv
// Memory stage: takes one instruction from EX, runs at most one data-memory access,
// and holds the aligned result on the mem->wb valid/ready link until WB takes it.
module cprv_mem_stage
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  output logic                  dmem_valid_o,
  input  logic                  dmem_ready_i,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [7:0]            dmem_wstrb_o,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] rdata_wb_o,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  output logic                  misalign_wb_o
);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] alu_q, rs2_q, rdata_q;
  logic [4:0]            rd_addr_q;
  logic                  rd_en_q, misalign_q;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;

  logic                  in_idle, is_mem_in, is_store_in, is_store_q, mis_in;
  logic [2:0]            off_sel, funct3_sel;
  logic                  store_sel;
  logic [DATA_WIDTH-1:0] wdata_a, load_a;
  logic [7:0]            wstrb_a;
  logic                  misalign_a;

  assign in_idle     = (state == ST_IDLE);
  assign is_store_in = (opcode_mem_i == OPC_STORE);
  assign is_mem_in   = (opcode_mem_i == OPC_LOAD) || is_store_in;
  assign is_store_q  = (opcode_q == OPC_STORE);

  // The aligner looks at incoming fields while IDLE (to decide misalignment before
  // capture) and at the captured fields afterwards, so REQ outputs stay stable.
  assign off_sel    = in_idle ? alu_out_mem_i[2:0] : alu_q[2:0];
  assign funct3_sel = in_idle ? funct3_mem_i : funct3_q;
  assign store_sel  = in_idle ? is_store_in : is_store_q;
  assign mis_in     = is_mem_in && misalign_a;

  cprv_lsu_align u_align (
    .off        (off_sel),
    .funct3     (funct3_sel),
    .is_store   (store_sel),
    .store_data (rs2_q),
    .load_word  (dmem_rdata_i),
    .wdata      (wdata_a),
    .wstrb      (wstrb_a),
    .load_data  (load_a),
    .misalign   (misalign_a)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      alu_q      <= '0;
      rs2_q      <= '0;
      rdata_q    <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (valid_mem_i) begin
          alu_q      <= alu_out_mem_i;
          rs2_q      <= rs2_data_mem_i;
          rdata_q    <= '0;
          rd_addr_q  <= rd_addr_mem_i;
          rd_en_q    <= rd_en_mem_i && !is_store_in && !mis_in;
          opcode_q   <= opcode_mem_i;
          funct3_q   <= funct3_mem_i;
          misalign_q <= mis_in;
          state      <= (is_mem_in && !mis_in) ? ST_REQ : ST_OUT;
        end
        ST_REQ: if (dmem_ready_i) state <= is_store_q ? ST_OUT : ST_WAIT;
        ST_WAIT: if (dmem_rvalid_i) begin
          rdata_q <= load_a;
          state   <= ST_OUT;
        end
        ST_OUT: if (ready_wb_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready_mem_o   = in_idle && !rst;
  assign dmem_valid_o  = (state == ST_REQ);
  assign dmem_we_o     = is_store_q;
  assign dmem_addr_o   = {alu_q[ADDR_WIDTH-1:3], 3'b000};
  assign dmem_wdata_o  = wdata_a;
  assign dmem_wstrb_o  = is_store_q ? wstrb_a : 8'h00;

  assign valid_wb_o    = (state == ST_OUT);
  assign alu_out_wb_o  = alu_q;
  assign rdata_wb_o    = rdata_q;
  assign rd_addr_wb_o  = rd_addr_q;
  assign rd_en_wb_o    = rd_en_q;
  assign opcode_wb_o   = opcode_q;
  assign funct3_wb_o   = funct3_q;
  assign misalign_wb_o = misalign_q;

endmodule

// File: tb/tb_cprv_mem_stage.sv
// Directed bench for cprv_mem_stage: expected WB results are queued at issue time
// and popped when the stage presents them; a small memory responder serves requests.
module tb_cprv_mem_stage;
  import cprv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_mem_i = 1'b0;
  logic        ready_mem_o;
  logic [63:0] alu_out_mem_i = '0;
  logic [63:0] rs2_data_mem_i = '0;
  logic [4:0]  rd_addr_mem_i = '0;
  logic        rd_en_mem_i = 1'b0;
  logic [6:0]  opcode_mem_i = '0;
  logic [2:0]  funct3_mem_i = '0;
  logic        dmem_valid_o, dmem_ready_i, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        valid_wb_o;
  logic        ready_wb_i = 1'b1;
  logic [63:0] alu_out_wb_o, rdata_wb_o;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [6:0]  opcode_wb_o;
  logic [2:0]  funct3_wb_o;
  logic        misalign_wb_o;

  logic        ready_stall = 1'b0;
  logic        suppress_rvalid = 1'b0;
  logic        force_rvalid = 1'b0;
  logic        rsp_rvalid = 1'b0;
  logic [63:0] load_word = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        rd_en;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        mis;
  } wb_exp_t;

  wb_exp_t sb[$];

  cprv_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .valid_mem_i    (valid_mem_i),
    .ready_mem_o    (ready_mem_o),
    .alu_out_mem_i  (alu_out_mem_i),
    .rs2_data_mem_i (rs2_data_mem_i),
    .rd_addr_mem_i  (rd_addr_mem_i),
    .rd_en_mem_i    (rd_en_mem_i),
    .opcode_mem_i   (opcode_mem_i),
    .funct3_mem_i   (funct3_mem_i),
    .dmem_valid_o   (dmem_valid_o),
    .dmem_ready_i   (dmem_ready_i),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_wstrb_o   (dmem_wstrb_o),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .valid_wb_o     (valid_wb_o),
    .ready_wb_i     (ready_wb_i),
    .alu_out_wb_o   (alu_out_wb_o),
    .rdata_wb_o     (rdata_wb_o),
    .rd_addr_wb_o   (rd_addr_wb_o),
    .rd_en_wb_o     (rd_en_wb_o),
    .opcode_wb_o    (opcode_wb_o),
    .funct3_wb_o    (funct3_wb_o),
    .misalign_wb_o  (misalign_wb_o)
  );

  always #5 clk = ~clk;

  // Memory model: zero-wait unless stalled; load data returns the cycle after the handshake.
  assign dmem_ready_i  = !ready_stall;
  assign dmem_rvalid_i = rsp_rvalid | force_rvalid;
  assign dmem_rdata_i  = load_word;

  always @(posedge clk)
    rsp_rvalid <= dmem_valid_o && dmem_ready_i && !dmem_we_o && !rst && !suppress_rvalid;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic wb_exp_t mk_exp(input logic [63:0] alu, input logic [63:0] rdata,
                                     input logic [4:0] rd, input logic rd_en,
                                     input logic [6:0] op, input logic [2:0] f3, input logic mis);
    mk_exp = '{alu: alu, rdata: rdata, rd: rd, rd_en: rd_en, op: op, f3: f3, mis: mis};
  endfunction

  // Returns at the falling edge just after the accepting rising edge.
  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic [63:0] alu, input logic [63:0] rs2,
                                input logic [4:0] rd, input logic rd_en);
    int t = 0;
    while (!ready_mem_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("issue_ready", 64'(ready_mem_o), 64'd1);
    valid_mem_i    = 1'b1;
    opcode_mem_i   = op;
    funct3_mem_i   = f3;
    alu_out_mem_i  = alu;
    rs2_data_mem_i = rs2;
    rd_addr_mem_i  = rd;
    rd_en_mem_i    = rd_en;
    @(posedge clk);
    #1;
    valid_mem_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_output(input int lat);
    int n = 1;
    wb_exp_t e;
    while (!valid_wb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_valid", 64'(valid_wb_o), 64'd1);
    if (lat != 0) chk("wb_latency", 64'(n), 64'(lat));
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("[TB] FAIL sb_pop: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("wb_alu", alu_out_wb_o, e.alu);
      chk("wb_rdata", rdata_wb_o, e.rdata);
      chk("wb_rd", 64'(rd_addr_wb_o), 64'(e.rd));
      chk("wb_rd_en", 64'(rd_en_wb_o), 64'(e.rd_en));
      chk("wb_opcode", 64'(opcode_wb_o), 64'(e.op));
      chk("wb_funct3", 64'(funct3_wb_o), 64'(e.f3));
      chk("wb_misalign", 64'(misalign_wb_o), 64'(e.mis));
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid_wb", 64'(valid_wb_o), 64'd0);
    chk("rst_dmem_valid", 64'(dmem_valid_o), 64'd0);
    chk("rst_misalign", 64'(misalign_wb_o), 64'd0);
    chk("rst_ready_mem", 64'(ready_mem_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready_mem", 64'(ready_mem_o), 64'd1);

    // ALU op passes straight through
    sb.push_back(mk_exp(64'h1234, 64'h0, 5'd5, 1'b1, OPC_OP, 3'b000, 1'b0));
    apply_stimulus(OPC_OP, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1);
    chk("add_no_dmem", 64'(dmem_valid_o), 64'd0);
    check_output(1);

    // SB at byte 3
    sb.push_back(mk_exp(64'h1003, 64'h0, 5'd0, 1'b0, OPC_STORE, 3'b000, 1'b0));
    apply_stimulus(OPC_STORE, 3'b000, 64'h1003, 64'hAB, 5'd0, 1'b1);
    chk("sb_dvalid", 64'(dmem_valid_o), 64'd1);
    chk("sb_addr", dmem_addr_o, 64'h1000);
    chk("sb_wstrb", 64'(dmem_wstrb_o), 64'h08);
    chk("sb_wdata", dmem_wdata_o, 64'h0000_0000_AB00_0000);
    chk("sb_we", 64'(dmem_we_o), 64'd1);
    check_output(2);

    // SH at byte 6
    sb.push_back(mk_exp(64'h1006, 64'h0, 5'd0, 1'b0, OPC_STORE, 3'b001, 1'b0));
    apply_stimulus(OPC_STORE, 3'b001, 64'h1006, 64'h1234, 5'd0, 1'b0);
    chk("sh_wstrb", 64'(dmem_wstrb_o), 64'hC0);
    chk("sh_wdata", dmem_wdata_o, 64'h1234_0000_0000_0000);
    check_output(2);

    // LB / LBU of byte 1
    load_word = 64'h0000_0000_0000_8000;
    sb.push_back(mk_exp(64'h2001, 64'hFFFF_FFFF_FFFF_FF80, 5'd10, 1'b1, OPC_LOAD, 3'b000, 1'b0));
    apply_stimulus(OPC_LOAD, 3'b000, 64'h2001, 64'h0, 5'd10, 1'b1);
    chk("lb_addr", dmem_addr_o, 64'h2000);
    chk("lb_we", 64'(dmem_we_o), 64'd0);
    chk("lb_wstrb", 64'(dmem_wstrb_o), 64'h00);
    check_output(3);
    sb.push_back(mk_exp(64'h2001, 64'h80, 5'd10, 1'b1, OPC_LOAD, 3'b100, 1'b0));
    apply_stimulus(OPC_LOAD, 3'b100, 64'h2001, 64'h0, 5'd10, 1'b1);
    check_output(3);

    // LH of top halfword
    load_word = 64'hBEEF_0000_0000_0000;
    sb.push_back(mk_exp(64'h2006, 64'hFFFF_FFFF_FFFF_BEEF, 5'd12, 1'b1, OPC_LOAD, 3'b001, 1'b0));
    apply_stimulus(OPC_LOAD, 3'b001, 64'h2006, 64'h0, 5'd12, 1'b1);
    check_output(3);

    // Misaligned LW
    sb.push_back(mk_exp(64'h2006, 64'h0, 5'd11, 1'b0, OPC_LOAD, 3'b010, 1'b1));
    apply_stimulus(OPC_LOAD, 3'b010, 64'h2006, 64'h0, 5'd11, 1'b1);
    chk("lw_mis_no_dmem", 64'(dmem_valid_o), 64'd0);
    check_output(1);

    // Memory stall then WB backpressure on an SD
    ready_wb_i  = 1'b0;
    ready_stall = 1'b1;
    sb.push_back(mk_exp(64'h3008, 64'h0, 5'd3, 1'b0, OPC_STORE, 3'b011, 1'b0));
    apply_stimulus(OPC_STORE, 3'b011, 64'h3008, 64'h1122_3344_5566_7788, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_dvalid", 64'(dmem_valid_o), 64'd1);
      chk("stall_addr", dmem_addr_o, 64'h3008);
      chk("stall_wdata", dmem_wdata_o, 64'h1122_3344_5566_7788);
      chk("stall_wstrb", 64'(dmem_wstrb_o), 64'hFF);
      chk("stall_ready_mem", 64'(ready_mem_o), 64'd0);
      if (i < 2) @(negedge clk);
    end
    ready_stall = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid_wb", 64'(valid_wb_o), 64'd1);
      chk("bp_alu", alu_out_wb_o, 64'h3008);
      chk("bp_dvalid", 64'(dmem_valid_o), 64'd0);
      chk("bp_ready_mem", 64'(ready_mem_o), 64'd0);
      @(negedge clk);
    end
    ready_wb_i = 1'b1;
    check_output(0);

    // Reset while waiting for load data; the late rvalid must be ignored
    suppress_rvalid = 1'b1;
    apply_stimulus(OPC_LOAD, 3'b011, 64'h4000, 64'h0, 5'd7, 1'b1);
    chk("w6_req", 64'(dmem_valid_o), 64'd1);
    @(negedge clk);
    chk("w6_wait_dvalid", 64'(dmem_valid_o), 64'd0);
    rst = 1'b1;
    #1;
    chk("w6_rst_ready_mem", 64'(ready_mem_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("w6_post_rst_dvalid", 64'(dmem_valid_o), 64'd0);
    force_rvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("w6_stale_valid_wb", 64'(valid_wb_o), 64'd0);
    end
    force_rvalid    = 1'b0;
    suppress_rvalid = 1'b0;
    @(negedge clk);
    chk("w6_ready_mem", 64'(ready_mem_o), 64'd1);
    sb.push_back(mk_exp(64'hCAFE, 64'h0, 5'd9, 1'b1, OPC_OP, 3'b000, 1'b0));
    apply_stimulus(OPC_OP, 3'b000, 64'hCAFE, 64'h0, 5'd9, 1'b1);
    check_output(1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
